// File: rtl/ldst_sequencer_if.sv
// Strobe interface between the load/store sequencer, its request source and the
// register-file / data-memory targets. The master modport is the sequencer's view.
interface ldst_sequencer_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [ADDR_W-1:0] req_addr;
    logic [REG_AW-1:0] req_reg;

    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;

    logic              rf_write_enable;
    logic              rf_read_enable;
    logic [REG_AW-1:0] rf_address;
    logic [DATA_W-1:0] rf_data_out;
    logic [DATA_W-1:0] rf_data_in;

    logic              busy;
    logic              done;
    logic [DATA_W-1:0] load_data;

    modport master (
        input  req_valid, req_is_store, req_addr, req_reg, mem_data_in, rf_data_in,
        output req_ready, mem_write_enable, mem_read_enable, mem_address, mem_data_out,
               rf_write_enable, rf_read_enable, rf_address, rf_data_out,
               busy, done, load_data
    );

    modport slave (
        output req_valid, req_is_store, req_addr, req_reg, mem_data_in, rf_data_in,
        input  req_ready, mem_write_enable, mem_read_enable, mem_address, mem_data_out,
               rf_write_enable, rf_read_enable, rf_address, rf_data_out,
               busy, done, load_data
    );
endinterface

// File: rtl/ldst_sequencer.sv
// Single-outstanding load/store sequencer: read strobe, optional wait, capture, write
// strobe, done. Every output is a register computed from the next state.
module ldst_sequencer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned REG_AW    = 4,
    parameter int unsigned READ_WAIT = 0
) (
    input logic              clk,
    input logic              reset,
    ldst_sequencer_if.master bus
);
    localparam logic [3:0] RdWaitCnt = 4'(READ_WAIT);

    typedef enum logic [2:0] {
        StIdle,
        StRdStb,
        StRdWait,
        StCapture,
        StWrStb,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [REG_AW-1:0] reg_q, reg_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              req_ready_q, req_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic              rf_we_q, rf_we_d;
    logic              rf_re_q, rf_re_d;
    logic [REG_AW-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_dout_q, rf_dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        addr_d      = addr_q;
        reg_d       = reg_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        load_data_d = load_data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid && req_ready_q) begin
                    is_store_d = bus.req_is_store;
                    addr_d     = bus.req_addr;
                    reg_d      = bus.req_reg;
                    state_d    = StRdStb;
                end
            end
            StRdStb: begin
                if (READ_WAIT != 0) begin
                    cnt_d   = RdWaitCnt;
                    state_d = StRdWait;
                end else begin
                    state_d = StCapture;
                end
            end
            StRdWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (is_store_q) begin
                    data_d = bus.rf_data_in;
                end else begin
                    data_d      = bus.mem_data_in;
                    load_data_d = bus.mem_data_in;
                end
                state_d = StWrStb;
            end
            StWrStb: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        req_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        rf_we_d     = 1'b0;
        rf_re_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        rf_addr_d   = rf_addr_q;
        rf_dout_d   = rf_dout_q;

        if (state_d == StRdStb) begin
            if (is_store_d) begin
                rf_re_d   = 1'b1;
                rf_addr_d = reg_d;
            end else begin
                mem_re_d   = 1'b1;
                mem_addr_d = addr_d;
            end
        end

        if (state_d == StWrStb) begin
            if (is_store_d) begin
                mem_we_d   = 1'b1;
                mem_addr_d = addr_d;
                mem_dout_d = data_d;
            end else begin
                rf_we_d   = 1'b1;
                rf_addr_d = reg_d;
                rf_dout_d = data_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            reg_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            req_ready_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_re_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_dout_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            reg_q       <= reg_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            req_ready_q <= req_ready_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            rf_we_q     <= rf_we_d;
            rf_re_q     <= rf_re_d;
            rf_addr_q   <= rf_addr_d;
            rf_dout_q   <= rf_dout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            load_data_q <= load_data_d;
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.mem_write_enable = mem_we_q;
    assign bus.mem_read_enable  = mem_re_q;
    assign bus.mem_address      = mem_addr_q;
    assign bus.mem_data_out     = mem_dout_q;
    assign bus.rf_write_enable  = rf_we_q;
    assign bus.rf_read_enable   = rf_re_q;
    assign bus.rf_address       = rf_addr_q;
    assign bus.rf_data_out      = rf_dout_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.load_data        = load_data_q;
endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer: two instances (READ_WAIT 0 and 2) share stimulus; a
// transaction-level model checks both every cycle, plus literal directed checks.
module tb_ldst_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       req_valid, req_is_store;
    logic [7:0] req_addr, mdi, rdi;
    logic [3:0] req_reg;

    ldst_sequencer_if #(.ADDR_W(8), .DATA_W(8), .REG_AW(4)) if0 ();
    ldst_sequencer_if #(.ADDR_W(8), .DATA_W(8), .REG_AW(4)) if2 ();

    assign if0.req_valid = req_valid;
    assign if0.req_is_store = req_is_store;
    assign if0.req_addr = req_addr;
    assign if0.req_reg = req_reg;
    assign if0.mem_data_in = mdi;
    assign if0.rf_data_in = rdi;
    assign if2.req_valid = req_valid;
    assign if2.req_is_store = req_is_store;
    assign if2.req_addr = req_addr;
    assign if2.req_reg = req_reg;
    assign if2.mem_data_in = mdi;
    assign if2.rf_data_in = rdi;

    ldst_sequencer #(.ADDR_W(8), .DATA_W(8), .REG_AW(4), .READ_WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    ldst_sequencer #(.ADDR_W(8), .DATA_W(8), .REG_AW(4), .READ_WAIT(2)) u_dut2 (
        .clk(clk), .reset(reset), .bus(if2)
    );

    typedef struct {
        logic       rst, rv, st;
        logic [7:0] addr, mdi, rdi;
        logic [3:0] rg;
        logic       rr, mwe, mre, rwe, rre, busy, done;
        logic [7:0] maddr, mdo, rdo, ld;
        logic [3:0] raddr;
    } obs_t;

    // k = cycle index inside the current operation (0 = idle, 1 = read strobe, ...).
    typedef struct {
        int         k;
        logic       st;
        logic [7:0] addr, data, ld;
        logic [3:0] rg;
    } mdl_t;

    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;
    mdl_t m0, m2;
    obs_t o0, o2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(inout mdl_t m, input obs_t o, input int w, input string t);
        bit rd = (m.k == 1);
        bit wr = (m.k == 3 + w);
        chk({t, ".req_ready"}, o.rr, m.k == 0);
        chk({t, ".busy"}, o.busy, m.k != 0);
        chk({t, ".done"}, o.done, m.k == 4 + w);
        chk({t, ".rf_re"}, o.rre, rd && m.st);
        chk({t, ".mem_re"}, o.mre, rd && !m.st);
        chk({t, ".mem_we"}, o.mwe, wr && m.st);
        chk({t, ".rf_we"}, o.rwe, wr && !m.st);
        chk({t, ".load_data"}, o.ld, m.ld);
        if (rd || m.k == 2) begin
            if (m.st) chk({t, ".rd_rf_addr"}, o.raddr, m.rg);
            else      chk({t, ".rd_mem_addr"}, o.maddr, m.addr);
        end
        if (wr || m.k == 4 + w) begin
            if (m.st) begin
                chk({t, ".wr_mem_addr"}, o.maddr, m.addr);
                chk({t, ".wr_mem_data"}, o.mdo, m.data);
            end else begin
                chk({t, ".wr_rf_addr"}, o.raddr, m.rg);
                chk({t, ".wr_rf_data"}, o.rdo, m.data);
            end
        end
        if (o.rst) begin
            m.k  = 0;
            m.ld = 8'h00;
        end else if (m.k == 0) begin
            if (o.rv) begin
                m.st   = o.st;
                m.addr = o.addr;
                m.rg   = o.rg;
                m.k    = 1;
            end
        end else begin
            if (m.k == 2 + w) begin
                m.data = m.st ? o.rdi : o.mdi;
                if (!m.st) m.ld = o.mdi;
            end
            m.k = (m.k == 4 + w) ? 0 : m.k + 1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            o0 = '{rst: reset, rv: req_valid, st: req_is_store, addr: req_addr, mdi: mdi,
                   rdi: rdi, rg: req_reg, rr: if0.req_ready, mwe: if0.mem_write_enable,
                   mre: if0.mem_read_enable, rwe: if0.rf_write_enable,
                   rre: if0.rf_read_enable, busy: if0.busy, done: if0.done,
                   maddr: if0.mem_address, mdo: if0.mem_data_out, rdo: if0.rf_data_out,
                   ld: if0.load_data, raddr: if0.rf_address};
            o2 = '{rst: reset, rv: req_valid, st: req_is_store, addr: req_addr, mdi: mdi,
                   rdi: rdi, rg: req_reg, rr: if2.req_ready, mwe: if2.mem_write_enable,
                   mre: if2.mem_read_enable, rwe: if2.rf_write_enable,
                   rre: if2.rf_read_enable, busy: if2.busy, done: if2.done,
                   maddr: if2.mem_address, mdo: if2.mem_data_out, rdo: if2.rf_data_out,
                   ld: if2.load_data, raddr: if2.rf_address};
            step(m0, o0, 0, "w0");
            step(m2, o2, 2, "w2");
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [7:0] a, input logic [3:0] r);
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_reg      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_addr = 8'h00;
        req_reg = 4'h0;
        mdi = 8'h00;
        rdi = 8'h00;
        m0 = '{k: 0, st: 1'b0, addr: 8'h00, data: 8'h00, ld: 8'h00, rg: 4'h0};
        m2 = m0;
        idle(2);
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst.strobes", {if0.mem_write_enable, if0.mem_read_enable,
                            if0.rf_write_enable, if0.rf_read_enable}, 4'b0000);
        chk("rst.busy_done", {if0.busy, if0.done}, 2'b00);
        chk("rst.req_ready", if0.req_ready, 1'b1);
        chk("rst.load_data", if0.load_data, 8'h00);
        chk("rst.mem_address", if0.mem_address, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        // Store reg 3 -> mem 0x40
        rdi = 8'hA5;
        issue(1'b1, 8'h40, 4'd3);
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("st.c1_rf_re", if0.rf_read_enable, 1'b1);
                chk("st.c1_rf_addr", if0.rf_address, 4'd3);
            end
            if (c == 2) chk("st.c2_rf_re", if0.rf_read_enable, 1'b0);
            if (c == 3) begin
                chk("st.c3_mem_we", if0.mem_write_enable, 1'b1);
                chk("st.c3_mem_addr", if0.mem_address, 8'h40);
                chk("st.c3_mem_data", if0.mem_data_out, 8'hA5);
            end
            if (c == 4) chk("st.c4_done", if0.done, 1'b1);
        end
        idle(8);

        // Load mem 0xFF -> reg 15 on both read-wait settings
        mdi = 8'h3C;
        issue(1'b0, 8'hFF, 4'd15);
        req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("ld.c1_mem_re", if0.mem_read_enable, 1'b1);
                chk("ld.c1_mem_addr", if0.mem_address, 8'hFF);
            end
            if (c == 3) begin
                chk("ld.c3_rf_we", if0.rf_write_enable, 1'b1);
                chk("ld.c3_rf_addr", if0.rf_address, 4'd15);
                chk("ld.c3_rf_data", if0.rf_data_out, 8'h3C);
                chk("ld.c3_load_data", if0.load_data, 8'h3C);
            end
            if (c == 4) chk("ld.c4_done", if0.done, 1'b1);
            if (c == 2 || c == 3 || c == 4)
                chk("ldw.quiet", {if2.mem_write_enable, if2.mem_read_enable,
                                  if2.rf_write_enable, if2.rf_read_enable}, 4'b0000);
            if (c == 5) begin
                chk("ldw.c5_rf_we", if2.rf_write_enable, 1'b1);
                chk("ldw.c5_rf_data", if2.rf_data_out, 8'h3C);
            end
            if (c == 6) chk("ldw.c6_done", if2.done, 1'b1);
            if (c == 7) chk("ldw.c7_ready", if2.req_ready, 1'b1);
        end
        idle(8);

        // req_valid held high with changing fields during a store
        rdi = 8'h5A;
        issue(1'b1, 8'h12, 4'd6);
        for (int c = 1; c <= 8; c++) begin
            if (c == 5) begin
                req_is_store = 1'b1;
                req_addr     = 8'h77;
                req_reg      = 4'd9;
            end else if (c < 5) begin
                req_is_store = 1'($urandom_range(0, 1));
                req_addr     = 8'($urandom);
                req_reg      = 4'($urandom);
            end
            if (c == 6) req_valid = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                chk("hold.c3_mem_addr", if0.mem_address, 8'h12);
                chk("hold.c3_mem_data", if0.mem_data_out, 8'h5A);
            end
            if (c == 4) chk("hold.c4_ready", if0.req_ready, 1'b0);
            if (c == 5) chk("hold.c5_ready_busy", {if0.req_ready, if0.busy}, 2'b10);
            if (c == 6) begin
                chk("hold.c6_rf_re", if0.rf_read_enable, 1'b1);
                chk("hold.c6_rf_addr", if0.rf_address, 4'd9);
            end
            if (c == 8) chk("hold.c8_mem_addr", if0.mem_address, 8'h77);
            @(posedge clk);
            #1;
        end
        idle(10);

        // Reset during the capture cycle of a store
        rdi = 8'hC3;
        issue(1'b1, 8'h55, 4'd2);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            chk("abort.mem_we", if0.mem_write_enable, 1'b0);
            chk("abort.done", if0.done, 1'b0);
            if (c == 3) chk("abort.c3_ready", if0.req_ready, 1'b1);
        end
        idle(2);

        // Randomised traffic with occasional resets
        repeat (3000) begin
            req_valid    = ($urandom_range(0, 3) != 0);
            req_is_store = 1'($urandom_range(0, 1));
            req_addr     = 8'($urandom);
            req_reg      = 4'($urandom);
            mdi          = 8'($urandom);
            rdi          = 8'($urandom);
            reset        = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        reset = 1'b0;
        idle(10);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
